// File: rtl/risc_ctrl_pkg.sv
// Shared types and constants for the pipeline front-end control blocks.
// Holds the fetch FSM state encoding and the register-index compare helper.
package risc_ctrl_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        STEP = 2'd3
    } fetch_state_t;

    // True when a source operand is actually read and names the given register.
    function automatic logic reg_match(input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] dst,
                                       input logic             used);
        return used && (src == dst);
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Hazard inputs and IF-stage control outputs exchanged between the pipeline
// datapath (master) and the fetch controller (slave).
interface fetch_ctrl_if
    import risc_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) ();

    logic                   branch_EX;
    logic                   MemRead_EX;
    logic [REG_W-1:0]       rd_EX;
    logic [REG_W-1:0]       rs1_ID;
    logic [REG_W-1:0]       rs2_ID;
    logic                   uses_rs1_ID;
    logic                   uses_rs2_ID;
    logic                   halt_req;
    logic                   step_req;

    logic                   PCSrc;
    logic                   PC_write;
    logic                   IF_ID_write;
    logic                   IF_ID_flush;
    logic                   ID_EX_flush;
    logic                   halted;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output branch_EX, MemRead_EX, rd_EX, rs1_ID, rs2_ID,
               uses_rs1_ID, uses_rs2_ID, halt_req, step_req,
        input  PCSrc, PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
               halted, stall_cycles
    );

    modport slave (
        input  branch_EX, MemRead_EX, rd_EX, rs1_ID, rs2_ID,
               uses_rs1_ID, uses_rs2_ID, halt_req, step_req,
        output PCSrc, PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush,
               halted, stall_cycles
    );

endinterface

// File: rtl/fetch_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID. Kept standalone so forwarding logic can reuse it.
module hazard_detect
    import risc_ctrl_pkg::*;
(
    input  logic             MemRead_EX,
    input  logic [REG_W-1:0] rd_EX,
    input  logic [REG_W-1:0] rs1_ID,
    input  logic [REG_W-1:0] rs2_ID,
    input  logic             uses_rs1_ID,
    input  logic             uses_rs2_ID,
    output logic             load_use
);

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = MemRead_EX && (rd_EX != '0) &&
                      (reg_match(rs1_ID, rd_EX, uses_rs1_ID) ||
                       reg_match(rs2_ID, rd_EX, uses_rs2_ID));

endmodule

// File: rtl/fetch_ctrl.sv
// Pipeline front-end controller: drives PC/IF/ID enables and flushes from
// branch, load-use and debug halt/step conditions; counts load-use stalls.
module fetch_ctrl
    import risc_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.slave  bus
);

    localparam int                BOOT_W    = $clog2(BOOT_CYCLES + 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

    localparam logic [1:0] S_BOOT = BOOT;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_HALT = HALT;
    localparam logic [1:0] S_STEP = STEP;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [BOOT_W-1:0]      boot_cnt;
    logic [STALL_CNT_W-1:0] stall_cnt;

    logic load_use;
    logic stall_now;
    logic pc_src;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic halted;

    hazard_detect u_hazard (
        .MemRead_EX  (bus.MemRead_EX),
        .rd_EX       (bus.rd_EX),
        .rs1_ID      (bus.rs1_ID),
        .rs2_ID      (bus.rs2_ID),
        .uses_rs1_ID (bus.uses_rs1_ID),
        .uses_rs2_ID (bus.uses_rs2_ID),
        .load_use    (load_use)
    );

    always_comb begin
        pc_src      = 1'b0;
        pc_write    = 1'b0;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        halted      = 1'b0;
        stall_now   = 1'b0;
        state_nxt   = state;

        case (state)
            S_BOOT: begin
                if_id_write = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt = S_RUN;
                end
            end

            S_RUN, S_STEP: begin
                // A taken branch kills both wrong-path slots, so any load-use
                // hazard on those slots is moot.
                if (bus.branch_EX) begin
                    pc_src      = 1'b1;
                    pc_write    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end else if (load_use) begin
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    stall_now   = 1'b1;
                end else begin
                    pc_write = 1'b1;
                end

                if (state == S_RUN) begin
                    if (bus.halt_req && !bus.branch_EX && !load_use) begin
                        state_nxt = S_HALT;
                    end
                end else if (pc_write) begin
                    state_nxt = S_HALT;
                end
            end

            S_HALT: begin
                halted      = 1'b1;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
                // Downstream keeps draining, so a late branch must still land.
                if (bus.branch_EX) begin
                    pc_src      = 1'b1;
                    pc_write    = 1'b1;
                    if_id_flush = 1'b1;
                end
                if (!bus.halt_req) begin
                    state_nxt = S_RUN;
                end else if (bus.step_req) begin
                    state_nxt = S_STEP;
                end
            end

            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    // Boot counter only advances while in BOOT; reset is the only way back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_BOOT;
            boot_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_BOOT) begin
                boot_cnt <= boot_cnt + 1'b1;
            end
            if (stall_now && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign bus.PCSrc        = pc_src;
    assign bus.PC_write     = pc_write;
    assign bus.IF_ID_write  = if_id_write;
    assign bus.IF_ID_flush  = if_id_flush;
    assign bus.ID_EX_flush  = id_ex_flush;
    assign bus.halted       = halted;
    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural model pushes expected outputs
// per cycle and a negedge monitor pops and compares them against the DUT.
module tb_fetch_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int STALL_CNT_W = 2;
    localparam int STALL_MAX   = (1 << STALL_CNT_W) - 1;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;
    localparam int M_STEP = 3;

    typedef struct {
        string tag;
        logic  pc_src;
        logic  pc_write;
        logic  if_id_write;
        logic  if_id_flush;
        logic  id_ex_flush;
        logic  halted;
        int    stall;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t exp_q[$];
    exp_t mon_e;

    int m_state, m_boot, m_stall;
    int n_state, n_boot, n_stall;

    fetch_ctrl_if #(.STALL_CNT_W(STALL_CNT_W)) bus ();

    fetch_ctrl #(
        .BOOT_CYCLES (BOOT_CYCLES),
        .STALL_CNT_W (STALL_CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs after the edge and queue what the outputs must be.
    task automatic apply_stimulus(input logic rst_v, input logic br, input logic mr,
                                  input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                                  input logic u1, input logic u2, input logic hq, input logic sq,
                                  input string tag);
        exp_t e;
        logic lu;
        @(posedge clk);
        #1;
        m_state = n_state;
        m_boot  = n_boot;
        m_stall = n_stall;
        reset           = rst_v;
        bus.branch_EX   = br;
        bus.MemRead_EX  = mr;
        bus.rd_EX       = rd;
        bus.rs1_ID      = r1;
        bus.rs2_ID      = r2;
        bus.uses_rs1_ID = u1;
        bus.uses_rs2_ID = u2;
        bus.halt_req    = hq;
        bus.step_req    = sq;
        if (!rst_v) begin
            m_state = M_BOOT;
            m_boot  = 0;
            m_stall = 0;
        end
        lu = mr && (rd != 5'd0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
        e.tag = tag;
        e.pc_src = 1'b0; e.pc_write = 1'b0; e.if_id_write = 1'b1;
        e.if_id_flush = 1'b0; e.id_ex_flush = 1'b0; e.halted = 1'b0;
        e.stall = m_stall;
        n_state = m_state; n_boot = m_boot; n_stall = m_stall;
        if (m_state == M_BOOT) begin
            e.if_id_write = 1'b0; e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
            n_boot = m_boot + 1;
            if (n_boot >= BOOT_CYCLES) n_state = M_RUN;
        end else if (m_state == M_HALT) begin
            e.halted = 1'b1; e.if_id_write = 1'b0; e.id_ex_flush = 1'b1;
            if (br) begin
                e.pc_src = 1'b1; e.pc_write = 1'b1; e.if_id_flush = 1'b1;
            end
            if (!hq) n_state = M_RUN;
            else if (sq) n_state = M_STEP;
        end else begin
            if (br) begin
                e.pc_src = 1'b1; e.pc_write = 1'b1; e.if_id_flush = 1'b1; e.id_ex_flush = 1'b1;
            end else if (lu) begin
                e.if_id_write = 1'b0; e.id_ex_flush = 1'b1;
                n_stall = (m_stall >= STALL_MAX) ? STALL_MAX : m_stall + 1;
            end else begin
                e.pc_write = 1'b1;
            end
            if (m_state == M_RUN && hq && !br && !lu) n_state = M_HALT;
            if (m_state == M_STEP && e.pc_write) n_state = M_HALT;
        end
        if (!rst_v) begin
            n_state = M_BOOT; n_boot = 0; n_stall = 0;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_output({mon_e.tag, ".PCSrc"},        int'(bus.PCSrc),        int'(mon_e.pc_src));
            check_output({mon_e.tag, ".PC_write"},     int'(bus.PC_write),     int'(mon_e.pc_write));
            check_output({mon_e.tag, ".IF_ID_write"},  int'(bus.IF_ID_write),  int'(mon_e.if_id_write));
            check_output({mon_e.tag, ".IF_ID_flush"},  int'(bus.IF_ID_flush),  int'(mon_e.if_id_flush));
            check_output({mon_e.tag, ".ID_EX_flush"},  int'(bus.ID_EX_flush),  int'(mon_e.id_ex_flush));
            check_output({mon_e.tag, ".halted"},       int'(bus.halted),       int'(mon_e.halted));
            check_output({mon_e.tag, ".stall_cycles"}, int'(bus.stall_cycles), mon_e.stall);
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        n_state = M_BOOT; n_boot = 0; n_stall = 0;
        reset = 1'b0;
        bus.branch_EX = 1'b0; bus.MemRead_EX = 1'b0; bus.rd_EX = '0;
        bus.rs1_ID = '0; bus.rs2_ID = '0; bus.uses_rs1_ID = 1'b0; bus.uses_rs2_ID = 1'b0;
        bus.halt_req = 1'b0; bus.step_req = 1'b0;

        for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "boot1");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "boot2");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "run_first");

        apply_stimulus(1, 0, 1, 5, 5, 0, 1, 0, 0, 0, "lu_rs1");
        apply_stimulus(1, 0, 0, 5, 5, 0, 1, 0, 0, 0, "after_lu");
        apply_stimulus(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, "rd_zero");
        apply_stimulus(1, 0, 1, 7, 3, 7, 1, 0, 0, 0, "rs2_unused");
        apply_stimulus(1, 0, 1, 7, 3, 7, 0, 1, 0, 0, "lu_rs2");
        apply_stimulus(1, 1, 1, 9, 9, 0, 1, 0, 0, 0, "br_over_lu");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");

        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "halt_entry");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "halted");
        apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, "halt_branch");
        apply_stimulus(1, 0, 1, 4, 4, 0, 1, 0, 1, 0, "halt_lu");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "step_req");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "step_adv");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "step_back");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "step_req2");
        apply_stimulus(1, 0, 1, 6, 0, 6, 0, 1, 1, 0, "step_stall");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "step_adv2");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "halt_again");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "unhalt");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rerun");

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, 1, 8, 8, 8, 1, 1, 0, 0, "sat_stall");
            apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "sat_gap");
        end

        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "halt_entry2");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, "step_req3");
        apply_stimulus(0, 0, 1, 2, 2, 0, 1, 0, 1, 0, "reset_mid_step");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, "reboot1");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reboot2");
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rerun2");

        for (int i = 0; i < 60; i++) begin
            apply_stimulus(1, ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), "rand");
        end

        @(negedge clk);
        #1;
        check_output("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Pipeline front-end controller that sequences the IF stage and the IF/ID and ID/EX pipeline registers. It generates PCSrc, PC_write, the IF/ID write enable and the IF/ID and ID/EX flushes, resolving three conditions: taken branches from EX, load-use hazards in ID, and debug halt/single-step. It also holds the pipeline empty for a fixed number of cycles after reset and counts load-use stall cycles for performance monitoring.

## Interface
- BOOT_CYCLES, 2: cycles held in BOOT after reset release (≥1)
- STALL_CNT_W, 16: width of stall-cycle counter

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- branch_EX  in  1  branch/jump in EX resolved taken
- MemRead_EX  in  1  instruction in EX is a load
- rd_EX  in  5  destination register of EX instruction
- rs1_ID, rs2_ID  in  5 each  source registers of ID instruction
- uses_rs1_ID, uses_rs2_ID  in  1 each  ID instruction reads rs1/rs2
- halt_req  in  1  debug halt request, level
- step_req  in  1  single-step request, pulse, honoured only in HALT
- PCSrc  out  1  select PC_Branch into PC
- PC_write  out  1  PC load enable
- IF_ID_write  out  1  IF/ID register load enable
- IF_ID_flush  out  1  clear IF/ID to NOP
- ID_EX_flush  out  1  clear ID/EX control to bubble
- halted  out  1  controller in HALT
- stall_cycles  out  STALL_CNT_W  saturating load-use stall count

## Operation
- States: BOOT, RUN, HALT, STEP. Held in BOOT while reset is low.
- load_use = MemRead_EX & (rd_EX≠0) & ((uses_rs1_ID & rs1_ID==rd_EX) | (uses_rs2_ID & rs2_ID==rd_EX)).
- BOOT: PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, PCSrc=0. Counter runs BOOT_CYCLES cycles, then goes to RUN. Inputs are ignored.
- RUN/STEP, evaluated in priority order:
  1. If branch_EX: PCSrc=1, PC_write=1, IF_ID_flush=1, ID_EX_flush=1. Both wrong-path slots are killed and load_use is ignored.
  2. Else if load_use: PC_write=0, IF_ID_write=0, ID_EX_flush=1, and stall_cycles increments.
  3. Else: PC_write=1, IF_ID_write=1, and no flush.
- RUN → HALT when halt_req=1 and neither branch_EX nor load_use is active. The current cycle still advances normally.
- HALT: halted=1, PC_write=0, IF_ID_write=0, ID_EX_flush=1 (downstream drains).
  - A branch_EX in HALT still redirects: PCSrc=1, PC_write=1, IF_ID_flush=1. The controller stays in HALT.
- HALT → RUN when halt_req=0. HALT → STEP when halt_req=1 and step_req=1 (step takes priority over nothing; halt_req=0 wins over step).
- STEP: behaves as RUN and sets halted=0. It returns to HALT after the first cycle with PC_write=1. While load_use stalls, it stays in STEP.
- Default values of PCSrc, IF_ID_flush and ID_EX_flush are 0 unless set above. Default of IF_ID_write is 1 except where set to 0.
- stall_cycles saturates at all-ones. It increments only on load-use stall cycles, never in BOOT or HALT.

## Timing
- Control outputs are combinational (Mealy) from state and the current-cycle inputs, so hazards act in the same cycle. State and counters update on the rising edge of clk.
- Reset is asynchronous. Asserting reset forces BOOT immediately, even mid-stall or mid-step, and sets stall_cycles=0. Outputs then take their BOOT values: halted=0, PC_write=0, IF_ID_write=0, both flushes 1, PCSrc=0.
- Release: the first RUN cycle is exactly BOOT_CYCLES rising edges after reset goes high.
- Load-use stall lasts 1 cycle. The load moves to MEM, so load_use clears on the next cycle.
- Taken-branch penalty is 2 cycles (two flushed slots).
- step_req asserted in the same cycle as entry into HALT is ignored; it is effective from the cycle after.

## Structure
- Package risc_ctrl_pkg: state enum fetch_state_t {BOOT, RUN, HALT, STEP}, and register-index width constant REG_W=5.
- Sub-module hazard_detect: purely combinational load_use compare, reusable by the forwarding logic.
- BOOT counter width is $clog2(BOOT_CYCLES+1).

## Test plan
- Reset low for 3 cycles, then released with BOOT_CYCLES=2 → PC_write=0 and both flushes=1 for 2 cycles; PC_write=1 on cycle 3.
- MemRead_EX=1, rd_EX=5, rs1_ID=5, uses_rs1_ID=1 → one cycle with PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cycles 0→1. With rd_EX=0 → no stall.
- branch_EX=1 coincident with load_use → PCSrc=1, PC_write=1, both flushes=1; stall_cycles unchanged.
- halt_req=1 in RUN → halted=1 the next cycle, PC frozen, ID_EX_flush=1. step_req pulse → exactly one PC advance, then halted=1 again. halt_req=0 → RUN.
- step_req pulsed while load_use is active in STEP → stays in STEP through the stall; returns to HALT after the single advancing cycle.
- Preload stall_cycles to all-ones via STALL_CNT_W=2 and 4 stalls → value holds 3. Reset asserted mid-STEP → BOOT immediately and stall_cycles=0.
